// File: rtl/result_bcd_converter.sv
// Serial double-dabble converter from a signed result to four display codes.
// Optional LEADING_ZERO_BLANK_EN macro turns leading zero digits into blanks.
module result_bcd_converter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [14:0] bin_in,
    input  logic        neg_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

    stateT       state, nextState;
    logic [3:0]  cnt;
    logic [30:0] sh, shNext;   // {bcd[15:0], bin[14:0]}
    logic        negR, ovfPend;
    logic        load, lastIter;
    logic [15:0] bcd, fmt;
    logic        isNeg;

    assign load     = (state != SHIFT) && start;
    assign lastIter = (state == SHIFT) && (cnt == 4'd14);
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    // One double-dabble iteration; any carry out of the thousands nibble is
    // dropped because such values are already flagged as overflow.
    always_comb begin
        logic [30:0] a;
        a = sh;
        for (int i = 0; i < 4; i++) begin
            if (a[15+4*i +: 4] >= 4'd5)
                a[15+4*i +: 4] = a[15+4*i +: 4] + 4'd3;
        end
        shNext = {a[29:0], 1'b0};
    end

    always_comb begin
        bcd   = shNext[30:15];
        fmt   = bcd;
        isNeg = negR && (bcd != 16'd0);
        if (ovfPend) begin
            fmt = 16'hEEEE;
        end else if (isNeg) begin
            fmt = {4'hB, 4'hA, bcd[7:0]};
`ifdef LEADING_ZERO_BLANK_EN
            if (bcd[7:4] == 4'd0) fmt[7:4] = 4'hF;
`endif
        end else begin
`ifdef LEADING_ZERO_BLANK_EN
            if (bcd[15:12] == 4'd0) begin
                fmt[15:12] = 4'hF;
                if (bcd[11:8] == 4'd0) begin
                    fmt[11:8] = 4'hF;
                    if (bcd[7:4] == 4'd0) fmt[7:4] = 4'hF;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = SHIFT;
            SHIFT:   if (lastIter) nextState = DONE;
            DONE:    nextState = start ? SHIFT : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            sh      <= 31'd0;
            negR    <= 1'b0;
            ovfPend <= 1'b0;
            digit0  <= 4'd0;
            digit1  <= 4'd0;
            digit2  <= 4'd0;
            digit3  <= 4'd0;
            ovf     <= 1'b0;
        end else if (load) begin
            cnt     <= 4'd0;
            sh      <= {16'd0, bin_in};
            negR    <= neg_in;
            ovfPend <= neg_in ? (bin_in > 15'd99) : (bin_in > 15'd9999);
        end else if (state == SHIFT) begin
            cnt <= cnt + 4'd1;
            sh  <= shNext;
            if (lastIter) begin
                digit0 <= fmt[3:0];
                digit1 <= fmt[7:4];
                digit2 <= fmt[11:8];
                digit3 <= fmt[15:12];
                ovf    <= ovfPend;
            end
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed and randomized bench for result_bcd_converter against a decimal
// arithmetic model of the display rules.
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        rst, start, negIn;
    logic [14:0] binIn;
    logic        busy, done, ovf;
    logic [3:0]  digit0, digit1, digit2, digit3;

    int tests = 0;
    int fails = 0;

    result_bcd_converter dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(binIn), .neg_in(negIn),
        .busy(busy), .done(done), .digit0(digit0), .digit1(digit1),
        .digit2(digit2), .digit3(digit3), .ovf(ovf)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] model(input int b, input bit n);
        logic [3:0] g3, g2, g1, g0;
        bit neg, ov;
        neg = n && (b != 0);
        ov  = neg ? (b > 99) : (b > 9999);
        g0 = 4'(b % 10);
        g1 = 4'((b / 10) % 10);
        g2 = 4'((b / 100) % 10);
        g3 = 4'((b / 1000) % 10);
        if (ov) begin
            {g3, g2, g1, g0} = 16'hEEEE;
        end else if (neg) begin
            g3 = 4'hB;
            g2 = 4'hA;
`ifdef LEADING_ZERO_BLANK_EN
            if (b < 10) g1 = 4'hF;
`endif
        end else begin
`ifdef LEADING_ZERO_BLANK_EN
            if (b < 1000) g3 = 4'hF;
            if (b < 100)  g2 = 4'hF;
            if (b < 10)   g1 = 4'hF;
`endif
        end
        return {ov, g3, g2, g1, g0};
    endfunction

    function automatic logic [16:0] outs();
        return {ovf, digit3, digit2, digit1, digit0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full conversion; inputs are scrambled right after the load edge to show
    // they are not sampled again.
    task automatic runConv(input string tag, input int b, input bit n);
        logic [16:0] e;
        int lat, bc;
        e = model(b, n);
        @(negedge clk);
        binIn = 15'(b); negIn = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0; binIn = 15'($urandom); negIn = 1'($urandom);
        lat = 0; bc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        // done is seen 15 edges after the load edge, i.e. in the 16th cycle
        chk({tag, ".lat"}, 32'(lat), 32'd15);
        chk({tag, ".busycyc"}, 32'(bc), 32'd15);
        chk({tag, ".busyAtDone"}, 32'(busy), 32'd0);
        chk({tag, ".digits"}, 32'(outs()), 32'(e));
        @(negedge clk);
        chk({tag, ".donePulse"}, 32'(done), 32'd0);
        chk({tag, ".hold"}, 32'(outs()), 32'(e));
    endtask

    initial begin
        int b, cntDone, lat;
        bit n;
        logic [16:0] got;
        rst = 1'b1; start = 1'b0; binIn = '0; negIn = 1'b0;
        #1;
        chk("reset.outs", 32'({busy, done, outs()}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        runConv("s1_9801", 9801, 1'b0);
        runConv("s2_neg42", 42, 1'b1);
        runConv("s3_10000", 10000, 1'b0);
        runConv("s3_neg150", 150, 1'b1);
        runConv("s4_7", 7, 1'b0);
        runConv("b_9999", 9999, 1'b0);
        runConv("b_neg99", 99, 1'b1);
        runConv("b_neg100", 100, 1'b1);
        runConv("b_zero", 0, 1'b0);
        runConv("b_negzero", 0, 1'b1);
        runConv("b_max", 32767, 1'b0);
        runConv("b_neg5", 5, 1'b1);
        runConv("b_1005", 1005, 1'b0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(3))
                0: begin b = int'($urandom_range(9999)); n = 1'b0; end
                1: begin b = int'($urandom_range(99)); n = 1'b1; end
                2: begin b = int'($urandom_range(32767)); n = 1'($urandom); end
                default: begin b = int'($urandom_range(9995, 10004)); n = 1'($urandom); end
            endcase
            runConv("rand", b, n);
        end

        // start pulse in the 5th SHIFT cycle is ignored
        @(negedge clk);
        binIn = 15'd1234; negIn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        binIn = 15'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cntDone = 0; got = '0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin cntDone++; got = outs(); end
            @(negedge clk);
        end
        chk("s5_ignore.count", 32'(cntDone), 32'd1);
        chk("s5_ignore.digits", 32'(got), 32'(model(1234, 1'b0)));

        // start held through DONE: back-to-back conversions every 16 cycles
        @(negedge clk);
        binIn = 15'd321; negIn = 1'b0; start = 1'b1;
        lat = 0;
        @(negedge clk);
        while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        chk("s5_b2b.first", 32'(outs()), 32'(model(321, 1'b0)));
        binIn = 15'd17; negIn = 1'b1;
        @(negedge clk);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        chk("s5_b2b.period", 32'(lat), 32'd16);
        chk("s5_b2b.second", 32'(outs()), 32'(model(17, 1'b1)));
        start = 1'b0;
        @(negedge clk);
        chk("s5_b2b.idle", 32'({busy, done}), 32'd0);

        // reset in the 8th SHIFT cycle aborts without a done pulse
        @(negedge clk);
        binIn = 15'd4321; negIn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("s6_busyBefore", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("s6_resetOuts", 32'({busy, done, outs()}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cntDone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1 || busy === 1'b1) cntDone++;
            @(negedge clk);
        end
        chk("s6_noActivity", 32'(cntDone), 32'd0);
        runConv("s6_negzero", 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
